// File: rtl/chip8_draw_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : chip8_draw_seq_pkg
//  Description : Shared constants and state encoding for the CHIP-8 DXYN
//                sprite-draw sequencer.
//                  CHIP8_ADDR_W : memory address width (12)
//                  CHIP8_DISP_W : display width in pixels (64)
//                  CHIP8_DISP_H : display height in pixels (32)
//                  draw_seq_state_t : 3-bit FSM state encoding
//  Revision    : 1.0 - initial release
// ============================================================================
package chip8_draw_seq_pkg;

    localparam int CHIP8_ADDR_W = 12;
    localparam int CHIP8_DISP_W = 64;
    localparam int CHIP8_DISP_H = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        DRAW = 3'd3,
        DONE = 3'd4
    } draw_seq_state_t;

endpackage : chip8_draw_seq_pkg
`default_nettype wire

// File: rtl/chip8_draw_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : chip8_draw_seq_if
//  Description : Memory-read and display-draw signals of the sprite-draw
//                sequencer.
//                  mem_req/mem_addr/mem_gnt/mem_rdata : arbiter read port
//                  draw/draw_x/draw_y/draw_row_index/sprite_data : display
//                  collision : display collision for the current draw cycle
//                master = sequencer side, slave = memory/display side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface chip8_draw_seq_if
    import chip8_draw_seq_pkg::*;
#(
    parameter int ADDR_W = CHIP8_ADDR_W
) ();

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic [7:0]        mem_rdata;

    logic              draw;
    logic [5:0]        draw_x;
    logic [4:0]        draw_y;
    logic [3:0]        draw_row_index;
    logic [7:0]        sprite_data;
    logic              collision;

    modport master (
        output mem_req, mem_addr, draw, draw_x, draw_y, draw_row_index, sprite_data,
        input  mem_gnt, mem_rdata, collision
    );

    modport slave (
        input  mem_req, mem_addr, draw, draw_x, draw_y, draw_row_index, sprite_data,
        output mem_gnt, mem_rdata, collision
    );

endinterface : chip8_draw_seq_if
`default_nettype wire

// File: rtl/chip8_draw_seq.sv
`default_nettype none
// ============================================================================
//  Module      : chip8_draw_seq
//  Description : Sequences one CHIP-8 DXYN sprite draw. Fetches N sprite
//                bytes starting at I, presents them row by row to the display
//                unit and ORs the per-row collision flags into vf_out.
//  Ports       : clk, reset (async, active-high)
//                start, x_in, y_in, n_in, i_addr : draw request from the CPU
//                busy, done, vf_out              : status back to the CPU
//                bus (chip8_draw_seq_if.master)  : memory port + display port
//  Options     : DRAW_SEQ_WRAP_EN - rows below the bottom edge wrap to the
//                top. Undefined (default): those rows and all later ones are
//                skipped (original CHIP-8 clipping).
//  Revision    : 1.0 - initial release
// ============================================================================
module chip8_draw_seq
    import chip8_draw_seq_pkg::*;
#(
    parameter int ADDR_W = CHIP8_ADDR_W,
    parameter int DISP_W = CHIP8_DISP_W,
    parameter int DISP_H = CHIP8_DISP_H
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              start,
    input  wire logic [7:0]        x_in,
    input  wire logic [7:0]        y_in,
    input  wire logic [3:0]        n_in,
    input  wire logic [ADDR_W-1:0] i_addr,
    output logic                   busy,
    output logic                   done,
    output logic                   vf_out,
    chip8_draw_seq_if.master       bus
);

    localparam logic [7:0] c_disp_w8 = 8'(DISP_W);
    localparam logic [7:0] c_disp_h8 = 8'(DISP_H);
    localparam logic [5:0] c_disp_h6 = 6'(DISP_H);

    draw_seq_state_t   r_state;
    draw_seq_state_t   w_state_nxt;

    logic [5:0]        r_x0;
    logic [4:0]        r_y0;
    logic [3:0]        r_n;
    logic [3:0]        r_row;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_sprite;
    logic [5:0]        r_draw_x;
    logic [4:0]        r_draw_y;
    logic [3:0]        r_draw_row;
    logic              r_vf;

    logic              w_mem_req;
    logic              w_draw;
    logic              w_done;
    logic              w_clip;
    logic [3:0]        w_row_inc;
    logic [5:0]        w_row_off;
    logic [4:0]        w_row_y;

    assign w_row_inc = r_row + 4'd1;
    // y0 < DISP_H and row <= 15, so 6 bits hold the unreduced sum.
    assign w_row_off = {1'b0, r_y0} + {2'b00, r_row};
    assign w_row_y   = 5'(w_row_off % c_disp_h6);

`ifdef DRAW_SEQ_WRAP_EN
    assign w_clip = 1'b0;
`else
    // The next row falls off the bottom edge: stop the sprite there.
    logic [5:0] w_next_off;
    assign w_next_off = w_row_off + 6'd1;
    assign w_clip     = (w_next_off >= c_disp_h6);
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and strobe decode. Strobes decode the state register
    // only, so they drop together with it on an asynchronous reset.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_mem_req   = 1'b0;
        w_draw      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = (n_in == 4'd0) ? DONE : REQ;
                end
            end
            REQ: begin
                w_mem_req = 1'b1;
                if (bus.mem_gnt) begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                w_state_nxt = DRAW;
            end
            DRAW: begin
                w_draw = 1'b1;
                if ((w_row_inc == r_n) || w_clip) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = REQ;
                end
            end
            DONE: begin
                w_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: request latch, row counter, address and draw registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x0       <= '0;
            r_y0       <= '0;
            r_n        <= '0;
            r_row      <= '0;
            r_base     <= '0;
            r_mem_addr <= '0;
            r_sprite   <= '0;
            r_draw_x   <= '0;
            r_draw_y   <= '0;
            r_draw_row <= '0;
            r_vf       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_x0       <= 6'(x_in % c_disp_w8);
                        r_y0       <= 5'(y_in % c_disp_h8);
                        r_n        <= n_in;
                        r_base     <= i_addr;
                        r_mem_addr <= i_addr;
                        r_row      <= '0;
                        r_vf       <= 1'b0;
                    end
                end
                WAIT: begin
                    // Read data is valid exactly one cycle after acceptance.
                    r_sprite   <= bus.mem_rdata;
                    r_draw_x   <= r_x0;
                    r_draw_y   <= w_row_y;
                    r_draw_row <= r_row;
                end
                DRAW: begin
                    r_vf       <= r_vf | bus.collision;
                    r_row      <= w_row_inc;
                    r_mem_addr <= r_base + ADDR_W'(w_row_inc);
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.mem_req        = w_mem_req;
    assign bus.mem_addr       = r_mem_addr;
    assign bus.draw           = w_draw;
    assign bus.draw_x         = r_draw_x;
    assign bus.draw_y         = r_draw_y;
    assign bus.draw_row_index = r_draw_row;
    assign bus.sprite_data    = r_sprite;

    assign busy   = (r_state != IDLE);
    assign done   = w_done;
    assign vf_out = r_vf;

endmodule : chip8_draw_seq
`default_nettype wire

// File: tb/tb_chip8_draw_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_chip8_draw_seq
//  Description : Self-checking bench for chip8_draw_seq. Table of directed
//                draw requests with hand-computed expectations, a small
//                memory/display bus model, plus hand-written sequences for
//                reset state and reset asserted mid-draw.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_chip8_draw_seq;
    import chip8_draw_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  x_in = '0;
    logic [7:0]  y_in = '0;
    logic [3:0]  n_in = '0;
    logic [11:0] i_addr = '0;
    logic        busy;
    logic        done;
    logic        vf_out;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mem [0:4095];

    chip8_draw_seq_if #(.ADDR_W(12)) bus ();

    chip8_draw_seq #(.ADDR_W(12), .DISP_W(64), .DISP_H(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .x_in   (x_in),
        .y_in   (y_in),
        .n_in   (n_in),
        .i_addr (i_addr),
        .busy   (busy),
        .done   (done),
        .vf_out (vf_out),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [3:0]  n;
        logic [11:0] addr;
        int          stall;     // grant withheld this many cycles on the row-1 request
        logic [15:0] coll;      // collision reported on draw of row k when bit k set
        bit          rs;        // extra start pulse while busy
        int          exp_draws;
        logic [5:0]  exp_x;
        logic [4:0]  exp_y;
        int          exp_done;
        bit          exp_vf;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          reads = 0;
        int          draws = 0;
        int          stall_left = v.stall;
        int          done_cyc = -1;
        int          excl_bad = 0;
        int          busy_bad = 0;
        logic        pend = 1'b0;
        logic [11:0] pend_addr = '0;
        logic [11:0] exp_addr;
        logic [11:0] spr_addr;
        @(negedge clk);
        x_in   = v.x;
        y_in   = v.y;
        n_in   = v.n;
        i_addr = v.addr;
        start  = 1'b1;
        bus.mem_gnt   = 1'b1;
        bus.collision = 1'b0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                start  = 1'b0;
                check($sformatf("v%0d vf_clear", idx), int'(vf_out), 0);
                x_in   = 8'hFF;
                y_in   = 8'hFF;
                n_in   = 4'hF;
                i_addr = 12'h0AA;
            end
            if (cyc == 2 && v.rs) start = 1'b1;
            if (cyc == 3) start = 1'b0;

            bus.collision = 1'b0;
            bus.mem_gnt   = 1'b1;
            bus.mem_rdata = pend ? mem[pend_addr] : 8'h00;
            pend = 1'b0;

            if ((int'(bus.mem_req) + int'(bus.draw) + int'(done)) > 1) excl_bad++;
            if (!busy) busy_bad++;

            if (bus.mem_req) begin
                exp_addr = v.addr + 12'(reads);
                check($sformatf("v%0d mem_addr r%0d", idx, reads), int'(bus.mem_addr), int'(exp_addr));
                if (reads == 1 && stall_left > 0) begin
                    bus.mem_gnt = 1'b0;
                    stall_left--;
                end else begin
                    pend      = 1'b1;
                    pend_addr = bus.mem_addr;
                    reads++;
                end
            end

            if (bus.draw) begin
                spr_addr = v.addr + 12'(draws);
                check($sformatf("v%0d draw_x r%0d", idx, draws), int'(bus.draw_x), int'(v.exp_x));
                check($sformatf("v%0d draw_y r%0d", idx, draws), int'(bus.draw_y), int'(5'(v.exp_y + 5'(draws))));
                check($sformatf("v%0d row_idx r%0d", idx, draws), int'(bus.draw_row_index), draws);
                check($sformatf("v%0d sprite r%0d", idx, draws), int'(bus.sprite_data), int'(mem[spr_addr]));
                bus.collision = v.coll[draws];
                draws++;
            end

            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        check($sformatf("v%0d done_cycle", idx), done_cyc, v.exp_done);
        check($sformatf("v%0d draws", idx), draws, v.exp_draws);
        check($sformatf("v%0d reads", idx), reads, v.exp_draws);
        check($sformatf("v%0d exclusive", idx), excl_bad, 0);
        check($sformatf("v%0d busy_high", idx), busy_bad, 0);
        check($sformatf("v%0d vf_at_done", idx), int'(vf_out), int'(v.exp_vf));
        bus.collision = 1'b0;
        bus.mem_gnt   = 1'b1;
        @(negedge clk);
        check($sformatf("v%0d busy_after", idx), int'(busy), 0);
        check($sformatf("v%0d vf_held", idx), int'(vf_out), int'(v.exp_vf));
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'((i * 7) + 3);
        mem[12'h300] = 8'hF0;
        mem[12'h301] = 8'h90;
        mem[12'h302] = 8'hF0;
        mem[12'hFFF] = 8'hA5;
        mem[12'h000] = 8'h3C;

        //            x      y      n     addr    stl coll      rs draws x      y      done vf
        vecs[0] = '{8'd10, 8'd5,  4'd3, 12'h300, 0, 16'h0000, 0, 3,  6'd10, 5'd5,  10, 0};
        vecs[1] = '{8'd10, 8'd5,  4'd3, 12'h300, 0, 16'h0002, 0, 3,  6'd10, 5'd5,  10, 1};
        vecs[2] = '{8'd10, 8'd5,  4'd3, 12'h300, 4, 16'h0000, 0, 3,  6'd10, 5'd5,  14, 0};
`ifdef DRAW_SEQ_WRAP_EN
        vecs[3] = '{8'd0,  8'd30, 4'd4, 12'h310, 0, 16'h0000, 0, 4,  6'd0,  5'd30, 13, 0};
`else
        vecs[3] = '{8'd0,  8'd30, 4'd4, 12'h310, 0, 16'h0000, 0, 2,  6'd0,  5'd30, 7,  0};
`endif
        vecs[4] = '{8'd1,  8'd1,  4'd0, 12'h400, 0, 16'h0000, 0, 0,  6'd1,  5'd1,  1,  0};
        vecs[5] = '{8'd2,  8'd3,  4'd2, 12'hFFF, 0, 16'h0000, 0, 2,  6'd2,  5'd3,  7,  0};
        vecs[6] = '{8'd70, 8'd40, 4'd1, 12'h123, 0, 16'h0001, 0, 1,  6'd6,  5'd8,  4,  1};
        vecs[7] = '{8'd63, 8'd0,  4'hF, 12'h200, 0, 16'h4000, 0, 15, 6'd63, 5'd0,  46, 1};
        vecs[8] = '{8'd10, 8'd5,  4'd3, 12'h300, 0, 16'h0000, 1, 3,  6'd10, 5'd5,  10, 0};

        bus.mem_gnt   = 1'b1;
        bus.mem_rdata = 8'h00;
        bus.collision = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst busy", int'(busy), 0);
        check("rst done", int'(done), 0);
        check("rst vf_out", int'(vf_out), 0);
        check("rst mem_req", int'(bus.mem_req), 0);
        check("rst mem_addr", int'(bus.mem_addr), 0);
        check("rst draw", int'(bus.draw), 0);
        check("rst draw_x", int'(bus.draw_x), 0);
        check("rst draw_y", int'(bus.draw_y), 0);
        check("rst row_idx", int'(bus.draw_row_index), 0);
        check("rst sprite", int'(bus.sprite_data), 0);

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Reset asserted in the WAIT state of row 1 (cycle 5)
        @(negedge clk);
        x_in = 8'd10; y_in = 8'd5; n_in = 4'd3; i_addr = 12'h300;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("mid busy_before", int'(busy), 1);
        check("mid addr_before", int'(bus.mem_addr), 12'h301);
        reset = 1'b1;
        #1;
        check("mid busy", int'(busy), 0);
        check("mid mem_req", int'(bus.mem_req), 0);
        check("mid draw", int'(bus.draw), 0);
        check("mid done", int'(done), 0);
        check("mid mem_addr", int'(bus.mem_addr), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("post busy", int'(busy), 0);
            check("post done", int'(done), 0);
            check("post mem_req", int'(bus.mem_req), 0);
        end
        run_vec(9, vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_chip8_draw_seq
`default_nettype wire

// File: doc/chip8_draw_seq.md
Name: chip8_draw_seq

Overview:
- Sequences one CHIP-8 DXYN sprite draw.
- Fetches N sprite bytes from memory starting at I and presents them one row at a time to the display unit.
- Accumulates the per-row collision flags into a VF result.
- Sits between the CPU execute stage, a memory arbiter port and chip8_display. The CPU issues start and waits for done.

Parameters:
- ADDR_W, 12, memory address width; address arithmetic wraps modulo 2^ADDR_W.
- DISP_W, 64, display width in pixels; the X origin is reduced modulo DISP_W.
- DISP_H, 32, display height in pixels; the Y origin is reduced modulo DISP_H.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle draw request; honoured only in IDLE.
- x_in  in  8  VX value.
- y_in  in  8  VY value.
- n_in  in  4  sprite height in rows.
- i_addr  in  ADDR_W  sprite base address (I register).
- mem_req  out  1  memory read request.
- mem_addr  out  ADDR_W  read address, valid while mem_req=1.
- mem_gnt  in  1  arbiter grant; the read is accepted when mem_req&mem_gnt.
- mem_rdata  in  8  read data, valid exactly one cycle after acceptance.
- draw  out  1  one-cycle strobe to the display unit.
- draw_x  out  6  sprite X origin.
- draw_y  out  5  Y of the current row.
- draw_row_index  out  4  current row number.
- sprite_data  out  8  current row byte.
- collision  in  1  display collision for the current draw cycle; combinational, valid while draw=1.
- busy  out  1  high from the cycle after start is accepted through DONE.
- done  out  1  one-cycle completion pulse.
- vf_out  out  1  accumulated collision; held until the next accepted start.

Behaviour:
- Reset values: state=IDLE; every output 0, including the registered draw_x, draw_y, draw_row_index, sprite_data, mem_addr and vf_out.

- IDLE:
  - On start, latch x0=x_in mod DISP_W, y0=y_in mod DISP_H, n=n_in, base=i_addr.
  - Clear row=0 and vf_out=0.
  - If n=0, go to DONE; otherwise go to REQ.

- REQ:
  - mem_req=1, mem_addr=(base+row) mod 2^ADDR_W.
  - Hold REQ with the address stable until mem_gnt=1, then go to WAIT.
  - No timeout.

- WAIT:
  - mem_req=0.
  - Capture mem_rdata into sprite_data.
  - Go to DRAW.

- DRAW:
  - draw=1 for exactly one cycle.
  - draw_x=x0, draw_y=(y0+row) mod DISP_H, draw_row_index=row.
  - vf_out <= vf_out | collision.
  - Then row <= row+1. If row+1==n, go to DONE; otherwise go to REQ, or to the clip rule below when applicable.

- DONE: done=1 for one cycle, then go to IDLE.

- Timing with permanent grant: 3 cycles per row.
  - Start accepted in cycle 0, first mem_req in cycle 1.
  - done asserts in cycle 1+3N. With n=0, done asserts in cycle 1.

- Start while busy is ignored. Inputs are sampled only on the accepted start.
- draw, mem_req and done are mutually exclusive in every cycle.
- Reset asserted mid-operation: return to IDLE immediately; mem_req, draw and done drop asynchronously; no done pulse is produced.
- X clipping and wrapping within a row is the display unit's responsibility. This block only passes x0.

Optional Feature:
- DRAW_SEQ_WRAP_EN defined:
  - Rows with y0+row ≥ DISP_H wrap to (y0+row) − DISP_H and are drawn normally.
- DRAW_SEQ_WRAP_EN undefined (default, original CHIP-8 clipping):
  - When y0+row ≥ DISP_H, that row and all later rows are skipped: no memory read, no draw.
  - The FSM goes directly from the last drawn DRAW (or from IDLE, if row 0 is already off-screen, which cannot happen since y0<DISP_H) to DONE.
  - vf_out reflects only the rows actually drawn.

Decomposition:
- chip8_pkg holds:
  - the DISP_W, DISP_H and ADDR_W constants;
  - the draw_seq_state_t enum {IDLE, REQ, WAIT, DRAW, DONE}, 3-bit encoding.
- No sub-module; a single FSM with a row counter is sufficient.

Test Plan:
1. x_in=10, y_in=5, n_in=3, i_addr=0x300, mem_gnt tied 1, memory {F0,90,F0}, collision=0 → reads at 0x300, 0x301, 0x302; three draw pulses with draw_y=5,6,7 and sprite_data=F0,90,F0; done at cycle 10; vf_out=0.
2. Same as scenario 1, with collision=1 only during the second draw → vf_out=1 at done; the next start clears vf_out to 0 in the following cycle.
3. mem_gnt held 0 for 4 cycles during the row-1 request → mem_addr stays 0x301 throughout; done is delayed by 4 cycles; no draw while waiting.
4. y_in=30, n_in=4 → with DRAW_SEQ_WRAP_EN: draw_y=30,31,0,1, four draws; without it: two draws (rows 30 and 31), two reads, done immediately after the second draw.
5. n_in=0 → done one cycle after start, no mem_req, no draw, vf_out=0. i_addr=0xFFF with n_in=2 → reads at 0xFFF then 0x000.
6. Reset pulsed while in WAIT of row 1 → draw, mem_req, done and busy go 0 immediately; after release the block is in IDLE and a new start runs scenario 1 correctly.
